// File: rtl/fifo_stream_reader.sv
// Read-domain consumer for asynFIFO: pops words via read_en/read_data and presents them as a
// valid/ready stream through a 3-entry prefetch buffer. Optional counter: FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader #(
    parameter int unsigned data_size = 8
) (
    input  logic                 read_clk,
    input  logic                 read_rst_n,
    input  logic                 fifo_empty,
    input  logic [data_size-1:0] fifo_read_data,
    output logic                 fifo_read_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [data_size-1:0] out_data
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    output logic [15:0]          pop_count
`endif
);

    logic [1:0]           r_occ;
    logic [1:0]           r_head;
    logic [1:0]           r_tail;
    logic                 r_inflight;
    logic [data_size-1:0] r_buf [3];

    logic [2:0] w_credit_used;
    logic       w_capture;
    logic       w_handshake;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts the in-flight word so a capture always finds a free entry.
    assign w_credit_used = {1'b0, r_occ} + {2'b00, r_inflight};
    assign fifo_read_en  = read_rst_n && !fifo_empty && (w_credit_used < 3'd3);

    assign w_capture   = r_inflight;
    assign out_valid   = (r_occ != 2'd0);
    assign out_data    = out_valid ? r_buf[r_head] : '0;
    assign w_handshake = out_valid && out_ready;

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            r_occ      <= 2'd0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_inflight <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= fifo_read_en;
            if (w_capture) begin
                r_buf[r_tail] <= fifo_read_data;
                r_tail        <= wrap_inc(r_tail);
            end
            if (w_handshake) begin
                r_head <= wrap_inc(r_head);
            end
            r_occ <= r_occ + {1'b0, w_capture} - {1'b0, w_handshake};
        end
    end

`ifdef FIFO_STREAM_READER_CNT_EN
    logic [15:0] r_pop_count;

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            r_pop_count <= 16'd0;
        end else if (w_handshake) begin
            r_pop_count <= r_pop_count + 16'd1;
        end
    end

    assign pop_count = r_pop_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural one-cycle-latency FIFO model.
module tb_fifo_stream_reader;

    logic       read_clk = 1'b0;
    logic       read_rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_read_data = 8'h00;
    logic       fifo_read_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef FIFO_STREAM_READER_CNT_EN
    logic [15:0] pop_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    int         pops = 0;
    int         bad_pops = 0;

    always #5 read_clk = ~read_clk;

    fifo_stream_reader #(.data_size(8)) dut (
        .read_clk       (read_clk),
        .read_rst_n     (read_rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_read_en   (fifo_read_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
`ifdef FIFO_STREAM_READER_CNT_EN
        ,
        .pop_count      (pop_count)
`endif
    );

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: word appears on fifo_read_data at the edge that sees read_en.
    always @(posedge read_clk) begin
        if (fifo_read_en && !fifo_empty) begin
            fifo_read_data <= mem[rd_ptr];
            rd_ptr         <= rd_ptr + 8'd1;
            pops           <= pops + 1;
        end else if (fifo_read_en && fifo_empty) begin
            bad_pops <= bad_pops + 1;
        end
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic test_reset();
        read_rst_n = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(negedge read_clk);
        read_rst_n = 1'b1;
        @(negedge read_clk);
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        repeat (3) @(negedge read_clk);
        n_cmp++;
        if (pops !== 3) begin
            n_fail++; $display("FAIL reset_prefill_pops: got %0d expected 3", pops);
        end
        read_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (fifo_read_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_read_en: got %b expected 0", fifo_read_en);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_cmp++;
        if (out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data);
        end
`ifdef FIFO_STREAM_READER_CNT_EN
        n_cmp++;
        if (pop_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_pop_count: got %0d expected 0", pop_count);
        end
`endif
        flush();
        @(negedge read_clk);
        read_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge read_clk);
            n_cmp++;
            if (fifo_read_en !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle: got read_en=%b valid=%b expected 0/0",
                         fifo_read_en, out_valid);
            end
        end
    endtask

    task automatic test_single();
        int p0;
        p0        = pops;
        out_ready = 1'b1;
        push(8'hA5);
        #1;
        n_cmp++;
        if (fifo_read_en !== 1'b1) begin
            n_fail++; $display("FAIL single_pop_issue: got %b expected 1", fifo_read_en);
        end
        @(negedge read_clk);
        n_cmp++;
        if (fifo_read_en !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_edge1: got read_en=%b valid=%b expected 0/0",
                     fifo_read_en, out_valid);
        end
        @(negedge read_clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_word: got valid=%b data=%h expected 1/a5", out_valid, out_data);
        end
        @(negedge read_clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got valid=%b expected 0", out_valid);
        end
        n_cmp++;
        if (pops - p0 !== 1) begin
            n_fail++; $display("FAIL single_pop_count: got %0d expected 1", pops - p0);
        end
    endtask

    task automatic test_streaming();
        int k;
        int first;
        int last;
        int gaps;
        k = 0; first = -1; last = -1; gaps = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int c = 1; c <= 20; c++) begin
            @(negedge read_clk);
            if (out_valid) begin
                n_cmp++;
                if (out_data !== 8'(k + 1)) begin
                    n_fail++;
                    $display("FAIL stream_data[%0d]: got %h expected %h", k, out_data, 8'(k + 1));
                end
                if (first < 0) first = c;
                if (last >= 0 && last != c - 1) gaps++;
                last = c;
                k++;
            end
        end
        n_cmp++;
        if (k !== 8) begin
            n_fail++; $display("FAIL stream_count: got %0d expected 8", k);
        end
        n_cmp++;
        if (gaps !== 0) begin
            n_fail++; $display("FAIL stream_gaps: got %0d expected 0", gaps);
        end
        n_cmp++;
        if (first !== 2) begin
            n_fail++; $display("FAIL stream_latency: got %0d expected 2", first);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        int k;
        p0        = pops;
        k         = 0;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int c = 0; c < 10; c++) begin
            @(negedge read_clk);
            if (c >= 5) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 8'h01) begin
                    n_fail++;
                    $display("FAIL bp_hold: got valid=%b data=%h expected 1/01",
                             out_valid, out_data);
                end
            end
        end
        n_cmp++;
        if (pops - p0 !== 3) begin
            n_fail++; $display("FAIL bp_pops: got %0d expected 3", pops - p0);
        end
        n_cmp++;
        if (fifo_read_en !== 1'b0) begin
            n_fail++; $display("FAIL bp_read_en: got %b expected 0", fifo_read_en);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                n_cmp++;
                if (out_data !== 8'(k + 1)) begin
                    n_fail++;
                    $display("FAIL bp_data[%0d]: got %h expected %h", k, out_data, 8'(k + 1));
                end
                k++;
            end
            @(negedge read_clk);
        end
        n_cmp++;
        if (k !== 8) begin
            n_fail++; $display("FAIL bp_count: got %0d expected 8", k);
        end
    endtask

    task automatic test_random_stall();
        logic [7:0] words [100];
        int         written;
        int         got;
        int         base;
        logic       v;
        logic       hs;
        logic [7:0] d;
        logic       prev_v;
        logic       prev_hs;
        logic [7:0] prev_d;
        written = 0; got = 0; base = pops;
        prev_v = 1'b0; prev_hs = 1'b0; prev_d = 8'h00;
        for (int i = 0; i < 100; i++) words[i] = 8'($urandom_range(0, 255));
        for (int c = 0; c < 3000 && got < 100; c++) begin
            v = out_valid;
            d = out_data;
            if (prev_v && !prev_hs) begin
                n_cmp++;
                if (v !== 1'b1 || d !== prev_d) begin
                    n_fail++;
                    $display("FAIL rand_stable: got valid=%b data=%h expected 1/%h", v, d, prev_d);
                end
            end
            n_cmp++;
            if (pops - base - got > 3) begin
                n_fail++;
                $display("FAIL rand_overflow: got %0d outstanding expected <=3", pops - base - got);
            end
            out_ready = 1'($urandom_range(0, 1));
            hs = v && out_ready;
            if (hs) begin
                n_cmp++;
                if (d !== words[got]) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: got %h expected %h", got, d, words[got]);
                end
                got++;
            end
            if (written < 100 && $urandom_range(0, 1) == 1) begin
                push(words[written]);
                written++;
            end
            prev_v = v; prev_d = d; prev_hs = hs;
            @(negedge read_clk);
        end
        n_cmp++;
        if (got !== 100) begin
            n_fail++; $display("FAIL rand_count: got %0d expected 100", got);
        end
        out_ready = 1'b1;
        repeat (4) @(negedge read_clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rand_extra_word: got valid=%b expected 0", out_valid);
        end
    endtask

`ifdef FIFO_STREAM_READER_CNT_EN
    task automatic test_counter();
        int pushed;
        int hs;
        pushed = 0; hs = 0;
        read_rst_n = 1'b0;
        flush();
        @(negedge read_clk);
        read_rst_n = 1'b1;
        out_ready  = 1'b1;
        @(negedge read_clk);
        n_cmp++;
        if (pop_count !== 16'd0) begin
            n_fail++; $display("FAIL cnt_start: got %0d expected 0", pop_count);
        end
        for (int c = 0; c < 71000 && hs < 70000; c++) begin
            if (out_valid && out_ready) hs++;
            if (pushed < 70000) begin
                push(8'(pushed));
                pushed++;
            end
            @(negedge read_clk);
        end
        repeat (4) @(negedge read_clk);
        n_cmp++;
        if (hs !== 70000) begin
            n_fail++; $display("FAIL cnt_handshakes: got %0d expected 70000", hs);
        end
        n_cmp++;
        if (pop_count !== 16'd4464) begin
            n_fail++; $display("FAIL cnt_wrap: got %0d expected 4464", pop_count);
        end
    endtask
`endif

    initial begin
        read_rst_n = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_random_stall();
`ifdef FIFO_STREAM_READER_CNT_EN
        test_counter();
`endif
        n_cmp++;
        if (bad_pops !== 0) begin
            n_fail++; $display("FAIL pop_while_empty: got %0d expected 0", bad_pops);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
